// File: rtl/seq_tx_11001_if.sv
// seq_tx_11001_if: start/count request and serial x/valid/busy/done response of the pattern transmitter.
// With SEQ_TX_ABORT_EN defined the bundle also carries the abort request.
interface seq_tx_11001_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
`ifdef SEQ_TX_ABORT_EN
    logic             abort;

    // Controller side
    modport master (output start, count, abort, input x, valid, busy, done);
    // Transmitter side
    modport slave  (input start, count, abort, output x, valid, busy, done);
`else
    // Controller side
    modport master (output start, count, input x, valid, busy, done);
    // Transmitter side
    modport slave  (input start, count, output x, valid, busy, done);
`endif
endinterface

// File: rtl/seq_tx_11001.sv
// seq_tx_11001: sends PATTERN MSB-first, count times, with GAP idle bits between repetitions.
// Optional: define SEQ_TX_ABORT_EN to add bus.abort, which cancels a running transfer.
module seq_tx_11001 #(
    parameter int unsigned     PLEN    = 5,
    parameter logic [PLEN-1:0] PATTERN = 5'b11001,
    parameter int unsigned     GAP     = 0,
    parameter int unsigned     CNT_W   = 4
) (
    input  logic          clk,
    input  logic          reset,
    seq_tx_11001_if.slave bus
);

    localparam int unsigned BIT_W = $clog2(PLEN);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PLEN - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state, state_n;
    logic [BIT_W-1:0] bit_idx, bit_n;
    logic [CNT_W-1:0] rep_left, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic             x_q, x_n;
    logic             valid_q, valid_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    // State, counters and all outputs are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            rep_left <= '0;
            gap_cnt  <= '0;
            x_q      <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_n;
            rep_left <= rep_n;
            gap_cnt  <= gap_n;
            x_q      <= x_n;
            valid_q  <= valid_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // Next state and next output values; bit_idx always names the bit currently on x
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        rep_n   = rep_left;
        gap_n   = gap_cnt;
        x_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (bus.start && (bus.count != '0)) begin
                    state_n = ST_SEND;
                    rep_n   = bus.count;
                    bit_n   = BIT_TOP;
                    x_n     = PATTERN[BIT_TOP];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ST_SEND: begin
                if (bit_idx != '0) begin
                    bit_n   = bit_idx - BIT_W'(1);
                    x_n     = PATTERN[bit_n];
                    valid_n = 1'b1;
                end else if (rep_left == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    rep_n = rep_left - CNT_W'(1);
                    if (GAP == 0) begin
                        bit_n   = BIT_TOP;
                        x_n     = PATTERN[BIT_TOP];
                        valid_n = 1'b1;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = GAP_TOP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt != '0) begin
                    gap_n = gap_cnt - GAP_W'(1);
                end else begin
                    state_n = ST_SEND;
                    bit_n   = BIT_TOP;
                    x_n     = PATTERN[BIT_TOP];
                    valid_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

`ifdef SEQ_TX_ABORT_EN
        // Abort drops a running transfer without a done pulse
        if (bus.abort && busy_q) begin
            state_n = ST_IDLE;
            bit_n   = '0;
            rep_n   = '0;
            gap_n   = '0;
            x_n     = 1'b0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
`endif
    end

    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_tx_11001.sv
// tb_seq_tx_11001: two transmitters (GAP=0 and GAP=2) on shared stimulus, checked every cycle
// against a queue-based transfer model, plus literal waveforms for the directed cases.
`timescale 1ns/1ps
module tb_seq_tx_11001;

    localparam int unsigned     PLEN  = 5;
    localparam logic [PLEN-1:0] PAT   = 5'b11001;
    localparam int unsigned     CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
`ifdef SEQ_TX_ABORT_EN
    logic             abort;
`endif

    always #5 clk = ~clk;

    seq_tx_11001_if #(.CNT_W(CNT_W)) if0 ();
    seq_tx_11001_if #(.CNT_W(CNT_W)) if1 ();

    assign if0.start = start;
    assign if0.count = count;
    assign if1.start = start;
    assign if1.count = count;
`ifdef SEQ_TX_ABORT_EN
    assign if0.abort = abort;
    assign if1.abort = abort;
`endif

    seq_tx_11001 #(.PLEN(PLEN), .PATTERN(PAT), .GAP(0), .CNT_W(CNT_W)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    seq_tx_11001 #(.PLEN(PLEN), .PATTERN(PAT), .GAP(2), .CNT_W(CNT_W)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Observed {x, valid, busy, done} per instance
    logic [3:0] obs [2];
    assign obs[0] = {if0.x, if0.valid, if0.busy, if0.done};
    assign obs[1] = {if1.x, if1.valid, if1.busy, if1.done};

    int errors = 0;
    int checks = 0;
    int done_cnt [2];
    bit armed = 1'b0;

    // Model: a whole transfer is expanded into a queue of per-cycle output words
    logic [3:0] q [2][$];
    logic [3:0] expv [2];

    task automatic model_step(input int d, input int gap);
        logic [PLEN-1:0] pat_v;
        int n;
        pat_v = PAT;
        if (reset) begin
            q[d].delete();
            expv[d] = 4'b0000;
        end
`ifdef SEQ_TX_ABORT_EN
        else if (abort && expv[d][1]) begin
            q[d].delete();
            expv[d] = 4'b0000;
        end
`endif
        else begin
            if ((q[d].size() == 0) && start && (count != '0)) begin
                n = int'(count);
                for (int r = 0; r < n; r++) begin
                    for (int b = PLEN - 1; b >= 0; b--) q[d].push_back({pat_v[b], 3'b110});
                    if (r < n - 1) begin
                        for (int g = 0; g < gap; g++) q[d].push_back(4'b0010);
                    end
                end
                q[d].push_back(4'b0001);
            end
            if (q[d].size() != 0) expv[d] = q[d].pop_front();
            else expv[d] = 4'b0000;
        end
    endtask

    // Every-cycle compare of both instances against the model
    initial begin
        expv[0] = 4'b0000;
        expv[1] = 4'b0000;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(posedge clk);
            if (reset) armed = 1'b1;
            model_step(0, 0);
            model_step(1, 2);
            @(negedge clk);
            if (armed) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs[d] !== expv[d]) begin
                        errors++;
                        $display("FAIL cycle_dut%0d t=%0t: x/valid/busy/done got %b required %b",
                                 d, $time, obs[d], expv[d]);
                    end
                    if (obs[d][0] === 1'b1) done_cnt[d]++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    logic [31:0] xs [2];
    logic [31:0] vs [2];
    logic [31:0] bs [2];
    logic [31:0] ds [2];

    // Shift in ncyc cycles of outputs, starting with the cycle already visible
    task automatic collect(input int ncyc);
        for (int d = 0; d < 2; d++) begin
            xs[d] = '0; vs[d] = '0; bs[d] = '0; ds[d] = '0;
        end
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                xs[d] = {xs[d][30:0], obs[d][3]};
                vs[d] = {vs[d][30:0], obs[d][2]};
                bs[d] = {bs[d][30:0], obs[d][1]};
                ds[d] = {ds[d][30:0], obs[d][0]};
            end
        end
    endtask

    // One-cycle start; returns at the negedge where the first bit is visible
    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        count = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        count = CNT_W'($urandom_range(0, 15));
    endtask

    int dc0, dc1;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        count = '0;
`ifdef SEQ_TX_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_state_dut0", 32'(obs[0]), 32'h0);
        chk("reset_state_dut1", 32'(obs[1]), 32'h0);
        reset = 1'b0;

        // Single pattern
        pulse_start(1);
        collect(7);
        chk("c1_x", 32'(xs[0][6:0]), 32'(7'b1100100));
        chk("c1_valid", 32'(vs[0][6:0]), 32'(7'b1111100));
        chk("c1_busy", 32'(bs[0][6:0]), 32'(7'b1111100));
        chk("c1_done", 32'(ds[0][6:0]), 32'(7'b0000010));
        chk("c1_x_gap2", 32'(xs[1][6:0]), 32'(7'b1100100));
        repeat (3) @(negedge clk);

        // Three back-to-back repetitions
        dc0 = done_cnt[0];
        pulse_start(3);
        collect(17);
        chk("c3_x", 32'(xs[0][16:0]), 32'({15'b110011100111001, 2'b00}));
        chk("c3_valid", 32'(vs[0][16:0]), 32'({15'h7fff, 2'b00}));
        chk("c3_busy", 32'(bs[0][16:0]), 32'({15'h7fff, 2'b00}));
        chk("c3_done", 32'(ds[0][16:0]), 32'(17'd2));
        chk("c3_done_pulses", 32'(done_cnt[0] - dc0), 32'd1);
        repeat (6) @(negedge clk);

        // Two repetitions: back-to-back vs two gap cycles
        pulse_start(2);
        collect(14);
        chk("c2_x", 32'(xs[0][13:0]), 32'({10'b1100111001, 4'b0000}));
        chk("c2_done", 32'(ds[0][13:0]), 32'(14'd8));
        chk("c2g_x", 32'(xs[1][13:0]), 32'(14'b11001001100100));
        chk("c2g_valid", 32'(vs[1][13:0]), 32'(14'b11111001111100));
        chk("c2g_busy", 32'(bs[1][13:0]), 32'(14'b11111111111100));
        chk("c2g_done", 32'(ds[1][13:0]), 32'(14'd2));
        repeat (3) @(negedge clk);

        // count=0 start is ignored
        pulse_start(0);
        #1;
        chk("cnt0_ignored_dut0", 32'(obs[0]), 32'h0);
        chk("cnt0_ignored_dut1", 32'(obs[1]), 32'h0);
        repeat (2) @(negedge clk);

        // start during bit 3 of a transfer is ignored
        dc0 = done_cnt[0];
        dc1 = done_cnt[1];
        pulse_start(2);
        repeat (2) @(negedge clk);
        start = 1'b1;
        count = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        chk("busy_start_done_dut0", 32'(done_cnt[0] - dc0), 32'd1);
        chk("busy_start_done_dut1", 32'(done_cnt[1] - dc1), 32'd1);
        chk("busy_start_idle_after", 32'(obs[0]), 32'h0);

        // start on the done edge is ignored, start on the next edge is accepted
        pulse_start(1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        count = 4'd1;
        @(negedge clk);
        #1;
        chk("done_edge_outputs", 32'(obs[0]), 32'(4'b0001));
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("after_done_accept", 32'(obs[0]), 32'(4'b1110));
        repeat (8) @(negedge clk);

        // Reset after the third bit of a count=2 transfer
        dc0 = done_cnt[0];
        pulse_start(2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset_dut0", 32'(obs[0]), 32'h0);
        chk("midreset_dut1", 32'(obs[1]), 32'h0);
        reset = 1'b0;
        pulse_start(1);
        collect(7);
        chk("post_reset_x", 32'(xs[0][6:0]), 32'(7'b1100100));
        chk("post_reset_done", 32'(ds[0][6:0]), 32'(7'b0000010));
        chk("post_reset_done_pulses", 32'(done_cnt[0] - dc0), 32'd1);
        repeat (3) @(negedge clk);

`ifdef SEQ_TX_ABORT_EN
        // Abort in IDLE does nothing; abort at the second bit cancels without done
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        dc0 = done_cnt[0];
        pulse_start(2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_dut0", 32'(obs[0]), 32'h0);
        chk("abort_dut1", 32'(obs[1]), 32'h0);
        pulse_start(1);
        collect(7);
        chk("post_abort_x", 32'(xs[0][6:0]), 32'(7'b1100100));
        chk("post_abort_done_pulses", 32'(done_cnt[0] - dc0), 32'd1);
        repeat (3) @(negedge clk);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            count = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) count = '0;
            reset = ($urandom_range(0, 199) == 0);
`ifdef SEQ_TX_ABORT_EN
            abort = ($urandom_range(0, 59) == 0);
`endif
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
`ifdef SEQ_TX_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
